// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory as little-endian
// 32-bit words, holding the CPU in reset until a clean image has been written.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  imem_loader_if.slave        bus_if,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  output logic                cpu_hold_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ADDR_W:0]     words_loaded_o
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StCsum, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [7:0]          csum_q, csum_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;

  logic                accept;
  logic [15:0]         n_full;
  logic                last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      n_q            <= '0;
      csum_q         <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      csum_q         <= csum_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    bus_if.byte_ready = 1'b0;
    busy_o            = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StData, StCsum: begin
        bus_if.byte_ready = 1'b1;
        busy_o            = 1'b1;
      end
      default: ;
    endcase
    done_o         = (state_q == StDone);
    error_o        = (state_q == StErr);
    cpu_hold_o     = (state_q != StDone);
    mem_we_o       = mem_we_q;
    mem_addr_o     = mem_addr_q;
    mem_wdata_o    = mem_wdata_q;
    words_loaded_o = words_loaded_q;
  end

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    csum_d         = csum_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q;

    accept    = bus_if.byte_valid && bus_if.byte_ready;
    n_full    = {bus_if.byte_in, n_q[7:0]};
    last_word = (32'(words_loaded_q) + 32'd1) == 32'(n_q);

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d        = StHdr0;
          n_d            = '0;
          csum_d         = '0;
          byte_idx_d     = '0;
          word_d         = '0;
          words_loaded_d = '0;
        end
      end
      StHdr0: begin
        if (accept) begin
          n_d[7:0] = bus_if.byte_in;
          csum_d   = csum_q ^ bus_if.byte_in;
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          n_d    = n_full;
          csum_d = csum_q ^ bus_if.byte_in;
          if (32'(n_full) > MAX_WORDS)  state_d = StErr;
          else if (n_full == 16'd0)     state_d = StCsum;
          else                          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          csum_d     = csum_q ^ bus_if.byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = bus_if.byte_in;
            2'd1: word_d[15:8]  = bus_if.byte_in;
            2'd2: word_d[23:16] = bus_if.byte_in;
            2'd3: begin
              // Word address is the pre-increment count; N <= MAX_WORDS keeps it in range.
              mem_we_d       = 1'b1;
              mem_addr_d     = words_loaded_q[ADDR_W-1:0];
              mem_wdata_d    = {bus_if.byte_in, word_q};
              words_loaded_d = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
              if (last_word) state_d = StCsum;
            end
          endcase
        end
      end
      StCsum: begin
        if (accept) state_d = (bus_if.byte_in == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames driven byte by byte, results checked against
// hand-computed words, addresses and checksums.
module tb_imem_loader;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold, busy, done, error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader_if bus_if ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .bus_if         (bus_if.slave),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .cpu_hold_o     (cpu_hold),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int we_count = 0;
  logic prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) we_count++;
    if (mem_we && prev_we) check("we_back_to_back", 32'(prev_we), 32'd0);
    prev_we = mem_we;
  end

  // Called at a negedge; returns at the negedge after the accepting edge (plus gap cycles).
  task automatic send_byte(input logic [7:0] b, input int gap, output logic acc,
                           output logic we, output logic [ADDR_W-1:0] addr,
                           output logic [31:0] data, output logic [ADDR_W:0] wl);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_in    = b;
    acc = bus_if.byte_ready;
    @(negedge clk);
    bus_if.byte_valid = 1'b0;
    we   = mem_we;
    addr = mem_addr;
    data = mem_wdata;
    wl   = words_loaded;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] b, input int gap);
    logic acc, we;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
    logic [ADDR_W:0] wl;
    send_byte(b, gap, acc, we, addr, data, wl);
    check("hdr_accepted", 32'(acc), 32'd1);
    check("hdr_no_we", 32'(we), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input int gap);
    logic acc, we;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
    logic [ADDR_W:0] wl;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], gap, acc, we, addr, data, wl);
      check("data_accepted", 32'(acc), 32'd1);
      check((i == 3) ? "we_after_4th" : "we_quiet", 32'(we), (i == 3) ? 32'd1 : 32'd0);
    end
    check("wr_addr", 32'(addr), 32'(idx));
    check("wr_data", data, w);
    check("wr_count", 32'(wl), 32'(idx + 1));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic acc_l, we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [31:0] data_l;
  logic [ADDR_W:0] wl_l;
  int we_base;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus_if.byte_valid = 1'b0;
    bus_if.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_if.byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;

    // Single word 0xDEADBEEF, checksum 0x23
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(bus_if.byte_ready), 32'd1);
    send_hdr(8'h01, 0);
    send_hdr(8'h00, 0);
    send_word(32'hDEADBEEF, 0, 0);
    send_byte(8'h23, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_ready_end", 32'(bus_if.byte_ready), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd1);
    check("t1_addr_hold", 32'(mem_addr), 32'd0);
    check("t1_data_hold", mem_wdata, 32'hDEADBEEF);
    check("t1_we_count", 32'(we_count), 32'd1);

    // Empty image
    we_base = we_count;
    pulse_start();
    send_hdr(8'h00, 0);
    send_hdr(8'h00, 0);
    send_byte(8'h00, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t2_done", 32'(done), 32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd0);
    check("t2_words", 32'(words_loaded), 32'd0);
    check("t2_no_we", 32'(we_count - we_base), 32'd0);

    // Bad checksum
    pulse_start();
    send_hdr(8'h01, 0);
    send_hdr(8'h00, 0);
    send_word(32'hDEADBEEF, 0, 0);
    send_byte(8'h24, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_ready", 32'(bus_if.byte_ready), 32'd0);

    // Oversize N=257
    we_base = we_count;
    pulse_start();
    send_hdr(8'h01, 0);
    send_byte(8'h01, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t4_error", 32'(error), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    send_byte(8'h55, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t4_not_accepted", 32'(acc_l), 32'd0);
    check("t4_no_we", 32'(we_count - we_base), 32'd0);

    // Gapped two-word image, checksum 0x46, start pulsed mid-load
    pulse_start();
    send_hdr(8'h02, 3);
    send_hdr(8'h00, 3);
    send_word(32'h11223344, 0, 3);
    pulse_start();
    check("t5_start_ignored_busy", 32'(busy), 32'd1);
    check("t5_start_ignored_words", 32'(words_loaded), 32'd1);
    send_word(32'hA5A55A5A, 1, 3);
    send_byte(8'h46, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t5_done", 32'(done), 32'd1);
    check("t5_words", 32'(words_loaded), 32'd2);
    check("t5_addr_hold", 32'(mem_addr), 32'd1);
    check("t5_data_hold", mem_wdata, 32'hA5A55A5A);

    // Reset in the middle of a four-word frame
    pulse_start();
    send_hdr(8'h04, 0);
    send_hdr(8'h00, 0);
    send_word(32'h03020100, 0, 0);
    send_word(32'h07060504, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_hold", 32'(cpu_hold), 32'd1);
    check("t6_words", 32'(words_loaded), 32'd0);
    check("t6_ready", 32'(bus_if.byte_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    pulse_start();
    send_hdr(8'h01, 0);
    send_hdr(8'h00, 0);
    send_word(32'hDEADBEEF, 0, 1);
    send_byte(8'h23, 0, acc_l, we_l, addr_l, data_l, wl_l);
    check("t6_reload_done", 32'(done), 32'd1);
    check("t6_reload_words", 32'(words_loaded), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
